// File: rtl/frac_baud_gen_if.sv
// Rate-control and strobe bundle between the UART CSR side and frac_baud_gen.
// The master drives the rate controls; the slave (generator) returns strobes and state.
interface frac_baud_gen_if #(
  parameter int MaxClockRate = 100000000,
  parameter int MinBaudRate  = 9600,
  parameter int Oversample   = 16,
  parameter int FracBits     = 4
);
  localparam int IntWidth = $clog2(MaxClockRate / (MinBaudRate * Oversample));
  localparam int OsWidth  = $clog2(Oversample);

  // Strobes are single-cycle level pulses qualified by the clk edge, with no
  // valid/ready handshake: a strobe is "active" when it differs from phase.
  logic                enable;
  logic                phase;
  logic [IntWidth-1:0] divInt;
  logic [FracBits-1:0] divFrac;
  logic                rxTick;
  logic                midTick;
  logic                txTick;
  logic                dbgPrimed;
  logic [OsWidth-1:0]  dbgOsCnt;

  modport master (
    output enable, phase, divInt, divFrac,
    input  rxTick, midTick, txTick, dbgPrimed, dbgOsCnt
  );

  modport slave (
    input  enable, phase, divInt, divFrac,
    output rxTick, midTick, txTick, dbgPrimed, dbgOsCnt
  );
endinterface

// File: rtl/frac_baud_gen.sv
// Fractional-divider baud generator: rx oversample, mid-bit and bit strobes.
// Optional feature macro: BAUD_FRAC_EN builds the fractional accumulator.
module frac_baud_gen #(
  parameter int MaxClockRate = 100000000,
  parameter int MinBaudRate  = 9600,
  parameter int Oversample   = 16,
  parameter int FracBits     = 4
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 syncReset,
  frac_baud_gen_if.slave       bus
);
  localparam int IntWidth = $clog2(MaxClockRate / (MinBaudRate * Oversample));
  localparam int OsWidth  = $clog2(Oversample);
  localparam int CntWidth = IntWidth + 1;
  localparam logic [OsWidth-1:0] OsLast = OsWidth'(Oversample - 1);
  localparam logic [OsWidth-1:0] OsMid  = OsWidth'(Oversample / 2 - 1);

  typedef enum logic {
    ST_UNPRIMED = 1'b0,
    ST_PRIMED   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_cnt_next;
  logic [OsWidth-1:0]  r_os_cnt;
  logic [OsWidth-1:0]  w_os_next;
  logic [CntWidth-1:0] w_div_eff;
  logic [CntWidth-1:0] w_period;
  logic [CntWidth-1:0] w_load;
  logic                w_carry;
  logic                w_tick;

  assign w_div_eff = (bus.divInt == '0) ? CntWidth'(1) : {1'b0, bus.divInt};

`ifdef BAUD_FRAC_EN
  logic [FracBits-1:0] r_acc;
  logic [FracBits:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, bus.divFrac};
  assign w_carry = w_sum[FracBits];

  // Accumulator advances only on ticks; priming always starts from acc==0.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_acc <= '0;
    end else if (syncReset) begin
      r_acc <= '0;
    end else if (w_tick) begin
      r_acc <= w_sum[FracBits-1:0];
    end
  end
`else
  logic w_unused_frac;
  assign w_unused_frac = ^bus.divFrac;
  assign w_carry       = 1'b0;
`endif

  assign w_period = w_div_eff + CntWidth'(w_carry);
  assign w_load   = w_period - CntWidth'(1);
  assign w_tick   = bus.enable && !syncReset && (r_state == ST_PRIMED) && (r_cnt == '0);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state  <= ST_UNPRIMED;
      r_cnt    <= '0;
      r_os_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_os_cnt <= w_os_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_os_next    = r_os_cnt;
    if (syncReset) begin
      w_state_next = ST_UNPRIMED;
      w_cnt_next   = '0;
      w_os_next    = '0;
    end else if (bus.enable) begin
      case (r_state)
        ST_UNPRIMED: begin
          w_state_next = ST_PRIMED;
          w_cnt_next   = w_load;
        end
        ST_PRIMED: begin
          if (r_cnt == '0) begin
            w_cnt_next = w_load;
            // Oversample is a power of two, so the natural wrap is the modulo.
            w_os_next  = r_os_cnt + OsWidth'(1);
          end else begin
            w_cnt_next = r_cnt - CntWidth'(1);
          end
        end
        default: w_state_next = ST_UNPRIMED;
      endcase
    end
  end

  assign bus.rxTick    = w_tick ^ bus.phase;
  assign bus.midTick   = (w_tick && (r_os_cnt == OsMid)) ^ bus.phase;
  assign bus.txTick    = (w_tick && (r_os_cnt == OsLast)) ^ bus.phase;
  assign bus.dbgPrimed = (r_state == ST_PRIMED);
  assign bus.dbgOsCnt  = r_os_cnt;
endmodule

// File: tb/tb_frac_baud_gen.sv
// Bench for frac_baud_gen: timestamp-based reference model feeds an expected
// queue; a negedge monitor compares every cycle's strobes and state.
module tb_frac_baud_gen;
  localparam int Oversample = 16;
  localparam int FracBits   = 4;
  localparam int IntWidth   = 10;
  localparam int OsWidth    = 4;
  localparam int Scale      = 16;
  localparam int EW         = OsWidth + 4;
`ifdef BAUD_FRAC_EN
  localparam bit FracOn = 1'b1;
`else
  localparam bit FracOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic nReset;
  logic syncReset;

  frac_baud_gen_if bus ();

  frac_baud_gen dut (
    .clk       (clk),
    .nReset    (nReset),
    .syncReset (syncReset),
    .bus       (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_popped = 0;
  int tick_times[$];
  int mid_times[$];
  int tx_times[$];

  // Reference model: ticks are absolute timestamps on an enabled-cycle clock.
  bit m_primed;
  int m_now;
  int m_next;
  int m_ticks;
  int m_frac;

  function automatic void model_clear();
    m_primed = 1'b0;
    m_now    = 0;
    m_next   = 0;
    m_ticks  = 0;
    m_frac   = 0;
  endfunction

  function automatic int rem();
    return m_next - m_now - 1;
  endfunction

  function automatic int q_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1000000;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic clear_times();
    tick_times.delete();
    mid_times.delete();
    tx_times.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [EW-1:0] e;
    logic t, mid, tx;
    int os, d, carry;
    if (!nReset) model_clear();
    os  = m_ticks % Oversample;
    t   = nReset && !syncReset && bus.enable && m_primed && (m_now + 1 == m_next);
    mid = t && (os == Oversample / 2 - 1);
    tx  = t && (os == Oversample - 1);
    e   = {m_primed, OsWidth'(os), t ^ bus.phase, mid ^ bus.phase, tx ^ bus.phase};
    exp_q.push_back(e);
    n_pushed++;
    d = (bus.divInt == '0) ? 1 : int'(bus.divInt);
    if (!nReset || syncReset) begin
      model_clear();
    end else if (bus.enable) begin
      if (!m_primed) begin
        m_primed = 1'b1;
        m_now    = 0;
        m_next   = d;
      end else begin
        m_now++;
        if (t) begin
          carry   = (FracOn && ((m_frac % Scale) + int'(bus.divFrac) >= Scale)) ? 1 : 0;
          m_frac += int'(bus.divFrac);
          m_next  = m_now + d + carry;
          m_ticks++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {bus.dbgPrimed, bus.dbgOsCnt, bus.rxTick, bus.midTick, bus.txTick};
      n_checks++;
      if (act !== e) begin
        n_errors++;
        $display("FAIL strobes cyc=%0d: got %b expected %b", n_popped, act, e);
      end
      if (bus.rxTick ^ bus.phase) tick_times.push_back(n_popped);
      if (bus.midTick ^ bus.phase) mid_times.push_back(n_popped);
      if (bus.txTick ^ bus.phase) tx_times.push_back(n_popped);
      n_popped++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0, r, c, s;
    nReset      = 1'b0;
    syncReset   = 1'b0;
    bus.enable  = 1'b1;
    bus.phase   = 1'b0;
    bus.divInt  = IntWidth'(4);
    bus.divFrac = '0;
    model_clear();
    @(posedge clk);
    #1;

    // Integer divide by 4: first tick P cycles after the priming cycle.
    repeat (3) step();
    check("reset_outputs", int'({bus.rxTick, bus.midTick, bus.txTick}), 0);
    nReset = 1'b1;
    clear_times();
    p0 = n_pushed;
    repeat (140) step();
    check("div4_first_tick", q_at(tick_times, 0) - p0, 4);
    check("div4_rx_period", q_at(tick_times, 1) - q_at(tick_times, 0), 4);
    check("div4_first_tx", q_at(tx_times, 0) - p0, 64);
    check("div4_tx_period", q_at(tx_times, 1) - q_at(tx_times, 0), 64);
    check("div4_mid_to_tx", q_at(tx_times, 0) - q_at(mid_times, 0), 32);

    // 10.5 clocks per tick.
    syncReset = 1'b1;
    step();
    syncReset   = 1'b0;
    bus.divInt  = IntWidth'(10);
    bus.divFrac = FracBits'(8);
    clear_times();
    repeat (200) step();
    check("frac_period_a", q_at(tick_times, 1) - q_at(tick_times, 0), 10);
    check("frac_period_b", q_at(tick_times, 2) - q_at(tick_times, 1), FracOn ? 11 : 10);
    check("frac_span16", q_at(tick_times, 16) - q_at(tick_times, 0), FracOn ? 168 : 160);

    // Inverted polarity at full rate, then reset with phase high.
    bus.phase   = 1'b1;
    bus.divInt  = '0;
    bus.divFrac = '0;
    syncReset   = 1'b1;
    step();
    syncReset = 1'b0;
    clear_times();
    repeat (40) step();
    check("full_rate_rx", q_at(tick_times, 5) - q_at(tick_times, 4), 1);
    check("full_rate_tx", q_at(tx_times, 1) - q_at(tx_times, 0), 16);
    nReset = 1'b0;
    #1;
    check("reset_phase_high", int'({bus.rxTick, bus.midTick, bus.txTick}), 7);
    repeat (3) step();
    nReset = 1'b1;

    // Enable gap of 7 cycles starting with cnt==2.
    bus.phase  = 1'b0;
    bus.divInt = IntWidth'(4);
    repeat (6) step();
    for (int i = 0; i < 20 && !(m_primed && rem() == 2); i++) step();
    check("gap_setup", rem(), 2);
    bus.enable = 1'b0;
    clear_times();
    repeat (7) step();
    check("gap_no_strobes", tick_times.size() + mid_times.size() + tx_times.size(), 0);
    bus.enable = 1'b1;
    r = n_pushed;
    repeat (8) step();
    check("gap_resume", q_at(tick_times, 0) - r, 2);

    // divInt change mid-period, then syncReset on a tick cycle.
    for (int i = 0; i < 20 && !(m_primed && rem() == 2); i++) step();
    check("chg_setup", rem(), 2);
    bus.divInt = IntWidth'(6);
    c = n_pushed;
    clear_times();
    for (int i = 0; i < 30 && tick_times.size() < 2; i++) step();
    check("chg_old_period", q_at(tick_times, 0) - c, 2);
    check("chg_new_period", q_at(tick_times, 1) - q_at(tick_times, 0), 6);
    for (int i = 0; i < 20 && !(m_primed && rem() == 0); i++) step();
    check("sr_setup", rem(), 0);
    syncReset = 1'b1;
    s = n_pushed;
    clear_times();
    step();
    syncReset = 1'b0;
    repeat (10) step();
    check("sr_restart", q_at(tick_times, 0) - s, 7);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.divInt = IntWidth'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) bus.divFrac = FracBits'($urandom_range(0, 15));
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) bus.phase = ~bus.phase;
      syncReset = ($urandom_range(0, 199) == 0);
      nReset    = ($urandom_range(0, 299) != 0);
      step();
    end
    nReset    = 1'b1;
    syncReset = 1'b0;
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
